// File: rtl/serdes_pkg.sv
// Shared constants and helpers for the 10b serial link blocks.
package serdes_pkg;

  localparam int SYM_W = 10;
  localparam logic [SYM_W-1:0] K28_5_RDN = 10'h17C;
  localparam logic [SYM_W-1:0] K28_5_RDP = 10'h283;

  typedef enum logic {SYNC, RUN} state_t;

  function automatic logic [3:0] popcount10(input logic [SYM_W-1:0] w);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < SYM_W; i++) n = n + {3'b000, w[i]};
    return n;
  endfunction

endpackage

// File: rtl/disparity_tracker.sv
// Running-disparity register and illegal-weight flag for 10b symbols.
module disparity_tracker
  import serdes_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             is_data,
  input  logic [SYM_W-1:0] word,
  output logic             rd,
  output logic             disp_err
);

  logic [3:0] ones;

  assign ones = popcount10(word);

  // balanced words leave RD alone; commas are never balanced, so they always flip it
  always_ff @(posedge clk) begin
    if (rst) begin
      rd       <= 1'b0;
      disp_err <= 1'b0;
    end else begin
      disp_err <= load && is_data && ((ones < 4'd4) || (ones > 4'd6));
      if (load) begin
        if (ones > 4'd5)      rd <= 1'b1;
        else if (ones < 4'd5) rd <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/serializer_10b.sv
// 10b symbol serializer: LSB-first shift-out, post-reset comma sync, comma idle fill.
//   state | meaning
//   SYNC  | sending SYNC_WORDS alignment commas, no data accepted
//   RUN   | sending held symbol, or an idle comma when none is held
module serializer_10b
  import serdes_pkg::*;
#(
  parameter int SYNC_WORDS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [SYM_W-1:0] data_10b_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             ser_out,
  output logic             word_start,
  output logic             idle_out,
  output logic             rd_out,
  output logic             disp_err
);

  localparam logic [7:0] SYNC_LAST = 8'(SYNC_WORDS - 1);

  state_t           state, state_next;
  logic [SYM_W-1:0] sr;
  logic [3:0]       bit_cnt;
  logic             hold_valid;
  logic [SYM_W-1:0] hold_data;
  logic [7:0]       sync_cnt;

  logic             load, accept;
  logic [SYM_W-1:0] next_word;
  logic             next_idle, next_is_data;

  assign load       = (bit_cnt == 4'd9);
  assign data_ready = (state == RUN) && !hold_valid;
  assign accept     = data_valid && data_ready;
  assign ser_out    = sr[0];

  always_ff @(posedge clk) begin
    if (rst) state <= SYNC;
    else     state <= state_next;
  end

  always_comb begin
    state_next   = state;
    next_word    = rd_out ? K28_5_RDP : K28_5_RDN;
    next_idle    = 1'b0;
    next_is_data = 1'b0;
    case (state)
      SYNC: if (load && (sync_cnt == SYNC_LAST)) state_next = RUN;
      RUN: begin
        if (hold_valid) begin
          next_word    = hold_data;
          next_is_data = 1'b1;
        end else begin
          next_idle = 1'b1;
        end
      end
      default: state_next = SYNC;
    endcase
  end

  // accept needs an empty hold and a data load needs a full one, so they never collide
  always_ff @(posedge clk) begin
    if (rst) begin
      sr         <= '0;
      bit_cnt    <= 4'd9;
      hold_valid <= 1'b0;
      hold_data  <= '0;
      sync_cnt   <= '0;
      word_start <= 1'b0;
      idle_out   <= 1'b0;
    end else begin
      if (load) begin
        sr         <= next_word;
        bit_cnt    <= 4'd0;
        word_start <= 1'b1;
        idle_out   <= next_idle;
        if (state == SYNC) sync_cnt <= sync_cnt + 8'd1;
        if (next_is_data)  hold_valid <= 1'b0;
      end else begin
        sr         <= {1'b0, sr[SYM_W-1:1]};
        bit_cnt    <= bit_cnt + 4'd1;
        word_start <= 1'b0;
      end
      if (accept) begin
        hold_valid <= 1'b1;
        hold_data  <= data_10b_in;
      end
    end
  end

  disparity_tracker u_disp (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .is_data  (next_is_data),
    .word     (next_word),
    .rd       (rd_out),
    .disp_err (disp_err)
  );

endmodule

// File: tb/tb_serializer_10b.sv
// Self-checking bench for serializer_10b: frame-level reference model plus directed sequences.
module tb_serializer_10b;

  localparam int SW = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] data_10b_in;
  logic       data_valid;
  logic       data_ready, ser_out, word_start, idle_out, rd_out, disp_err;

  int total = 0;
  int bad   = 0;

  serializer_10b #(.SYNC_WORDS(SW)) dut (
    .clk         (clk),
    .rst         (rst),
    .data_10b_in (data_10b_in),
    .data_valid  (data_valid),
    .data_ready  (data_ready),
    .ser_out     (ser_out),
    .word_start  (word_start),
    .idle_out    (idle_out),
    .rd_out      (rd_out),
    .disp_err    (disp_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: frames start every 10 edges after reset release;
  // the first SW frames are commas, then held symbol or idle comma.
  bit         m_live = 0;
  int         m_k, m_frames;
  logic       m_rd, m_derr, m_idle;
  logic [9:0] m_word;
  logic [9:0] m_hold[$];

  always @(posedge clk) begin
    bit rdy, acc, dat;
    int ones;
    m_live = 1;
    if (rst) begin
      m_k = 0; m_frames = 0; m_rd = 0; m_derr = 0; m_idle = 0; m_word = '0;
      m_hold.delete();
    end else begin
      rdy    = (m_frames >= SW) && (m_hold.size() == 0);
      acc    = data_valid && rdy;
      m_derr = 0;
      if (m_k % 10 == 0) begin
        dat = 0;
        if (m_frames < SW) begin
          m_word = m_rd ? 10'h283 : 10'h17C; m_idle = 0;
        end else if (m_hold.size() != 0) begin
          m_word = m_hold.pop_front(); m_idle = 0; dat = 1;
        end else begin
          m_word = m_rd ? 10'h283 : 10'h17C; m_idle = 1;
        end
        ones = $countones(m_word);
        if (ones > 5)      m_rd = 1;
        else if (ones < 5) m_rd = 0;
        m_derr = dat && (ones < 4 || ones > 6);
        if (m_frames < SW) m_frames++;
      end
      if (acc) m_hold.push_back(data_10b_in);
      m_k++;
    end
  end

  always @(negedge clk) begin
    logic [5:0] exp_v;
    if (m_live) begin
      exp_v = {(m_k == 0) ? 1'b0 : m_word[(m_k - 1) % 10],
               (m_k > 0) && ((m_k - 1) % 10 == 0),
               m_idle, m_rd,
               (m_frames >= SW) && (m_hold.size() == 0),
               m_derr};
      chk("cycle{ser,ws,idle,rd,ready,derr}",
          {ser_out, word_start, idle_out, rd_out, data_ready, disp_err}, exp_v);
    end
  end

  task automatic send(input logic [9:0] s);
    bit ok = 0;
    data_10b_in = s;
    data_valid  = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (data_ready) begin ok = 1; break; end
      @(negedge clk);
    end
    chk("accept", ok, 1);
    if (ok) @(negedge clk);
  endtask

  task automatic wait_ws();
    bit found = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (word_start) begin found = 1; break; end
    end
    chk("word_start_seen", found, 1);
  endtask

  task automatic capture(output logic [9:0] w, output int waited,
                         output logic rd_at, output logic rdy_at, output logic derr_at);
    bit found = 0;
    waited = 0;
    w = '0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      waited++;
      if (word_start && !idle_out) begin found = 1; break; end
    end
    chk("capture_found", found, 1);
    rd_at   = rd_out;
    rdy_at  = data_ready;
    derr_at = disp_err;
    w[0]    = ser_out;
    for (int b = 1; b < 10; b++) begin
      @(negedge clk);
      w[b] = ser_out;
    end
  endtask

  typedef struct {
    logic [9:0] sym;
    logic       rd;
    logic       derr;
  } vec_t;

  vec_t tbl[12];

  initial begin
    #1_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [39:0] bits40;
    logic [9:0]  w;
    int          waited;
    logic        rd_at, rdy_at, derr_at, rd_before;

    tbl[0]  = '{10'h0F7, 1'b1, 1'b1};
    tbl[1]  = '{10'h308, 1'b0, 1'b1};
    tbl[2]  = '{10'h17C, 1'b1, 1'b0};
    tbl[3]  = '{10'h3FF, 1'b1, 1'b1};
    tbl[4]  = '{10'h2AA, 1'b1, 1'b0};
    tbl[5]  = '{10'h000, 1'b0, 1'b1};
    tbl[6]  = '{10'h2AA, 1'b0, 1'b0};
    tbl[7]  = '{10'h0FF, 1'b1, 1'b1};
    tbl[8]  = '{10'h1F0, 1'b1, 1'b0};
    tbl[9]  = '{10'h00F, 1'b0, 1'b0};
    tbl[10] = '{10'h03F, 1'b1, 1'b0};
    tbl[11] = '{10'h155, 1'b1, 1'b0};

    rst = 1'b1; data_valid = 1'b0; data_10b_in = '0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {ser_out, word_start, idle_out, rd_out, data_ready, disp_err}, 0);
    rst = 1'b0;

    // sync commas after reset
    wait_ws();
    bits40 = '0;
    for (int i = 0; i < 40; i++) begin
      if (i > 0) @(negedge clk);
      bits40[i] = ser_out;
      if (i % 10 == 0) chk("sync_word_start", word_start, 1);
      if (i == 29) chk("sync_ready_low", data_ready, 0);
      if (i == 30) chk("sync_ready_high", data_ready, 1);
    end
    chk("sync_commas", bits40, {10'h283, 10'h17C, 10'h283, 10'h17C});
    @(negedge clk);
    chk("idle_after_sync", {word_start, idle_out}, 2'b11);

    // single balanced symbol accepted mid-frame
    wait_ws();
    repeat (4) @(negedge clk);
    rd_before = rd_out;
    send(10'h2AA);
    chk("ready_drop", data_ready, 0);
    data_valid = 1'b0;
    capture(w, waited, rd_at, rdy_at, derr_at);
    chk("single_word", w, 10'h2AA);
    chk("single_rd", rd_at, rd_before);
    chk("single_ready_back", rdy_at, 1);

    // back-to-back table, valid held high
    fork
      begin
        for (int j = 0; j < 12; j++) send(tbl[j].sym);
        data_valid = 1'b0;
      end
      begin
        logic [9:0] cw;
        int         cwait;
        logic       crd, crdy, cderr;
        for (int j = 0; j < 12; j++) begin
          capture(cw, cwait, crd, crdy, cderr);
          chk($sformatf("tbl%0d_word", j), cw, tbl[j].sym);
          chk($sformatf("tbl%0d_rd", j), crd, tbl[j].rd);
          chk($sformatf("tbl%0d_derr", j), cderr, tbl[j].derr);
          if (j > 0) chk($sformatf("tbl%0d_gap", j), cwait, 1);
        end
      end
    join

    // valid raised exactly on the load cycle with hold empty
    repeat (20) @(negedge clk);
    wait_ws();
    repeat (9) @(negedge clk);
    chk("ready_before_load", data_ready, 1);
    data_10b_in = 10'h0AB;
    data_valid  = 1'b1;
    @(negedge clk);
    chk("load_cycle_comma", {word_start, idle_out}, 2'b11);
    chk("load_cycle_accepted", data_ready, 0);
    data_valid = 1'b0;
    capture(w, waited, rd_at, rdy_at, derr_at);
    chk("load_cycle_next_frame", waited, 10);
    chk("load_cycle_word", w, 10'h0AB);

    // reset in the middle of a data word with hold full
    repeat (12) @(negedge clk);
    send(10'h2D2);
    data_10b_in = 10'h111;
    begin
      bit found = 0;
      for (int c = 0; c < 40; c++) begin
        @(negedge clk);
        if (word_start && !idle_out) begin found = 1; break; end
      end
      chk("rst_word_seen", found, 1);
    end
    repeat (4) @(negedge clk);
    rst = 1'b1;
    data_valid = 1'b0;
    @(negedge clk);
    chk("midword_reset", {ser_out, word_start, idle_out, rd_out, data_ready, disp_err}, 0);
    rst = 1'b0;
    capture(w, waited, rd_at, rdy_at, derr_at);
    chk("resync_first_comma", w, 10'h17C);
    repeat (31) @(negedge clk);
    chk("hold_emptied", {word_start, idle_out}, 2'b11);

    // randomized traffic against the model
    for (int n = 0; n < 150; n++) begin
      data_valid = 1'b0;
      repeat ($urandom_range(0, 12)) @(negedge clk);
      send(10'($urandom_range(0, 1023)));
    end
    data_valid = 1'b0;
    repeat (30) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
